// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - framed packet parser behind a UART byte receiver
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hAA,
  parameter int         TIMEOUT_CLKS = 17360
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       last_o,
  output logic       frame_ok_o,
  output logic       chk_err_o,
  output logic       len_err_o,
  output logic       overrun_o,
  output logic       timeout_o,
  output logic       busy_o
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN} state_t;

  state_t          state, next_state;
  logic [7:0]      len_q, chk_acc;
  logic [IW-1:0]   idx, rd_idx, rd_next;
  logic [7:0]      pbuf [0:(1<<AW)-1];

  logic [7:0]      n_data, n_len, n_chk;
  logic [IW-1:0]   n_idx, n_rd;
  logic            n_valid, n_last, n_ok, n_cerr, n_lerr, n_ovr, n_busy;
  logic            wr_en, len_ok, idx_last, rd_last, handshake, tmo_hit;

  assign len_ok    = (byte_i != 8'd0) && (byte_i <= 8'(MAX_LEN));
  assign idx_last  = (8'(idx) == len_q - 8'd1);
  assign rd_next   = rd_idx + IW'(1);
  assign rd_last   = (8'(rd_next) == len_q - 8'd1);
  assign handshake = valid_o && ready_i;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] tcnt;
  logic          active;

  assign active  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHECK);
  // A byte in the expiry cycle wins, so the abort needs a silent cycle.
  assign tmo_hit = active && !byte_valid_i && (tcnt == TW'(TIMEOUT_CLKS));

  always_ff @(posedge clk) begin
    if (rst || !active || byte_valid_i || tmo_hit) tcnt <= '0;
    else                                            tcnt <= tcnt + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_HUNT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_HUNT:    if (byte_valid_i && byte_i == SYNC_BYTE) next_state = S_LEN;
      S_LEN:     if (byte_valid_i) next_state = len_ok ? S_PAYLOAD : S_HUNT;
      S_PAYLOAD: if (byte_valid_i && idx_last) next_state = S_CHECK;
      S_CHECK:   if (byte_valid_i) next_state = (byte_i == chk_acc) ? S_DRAIN : S_HUNT;
      S_DRAIN:   if (handshake && last_o) next_state = S_HUNT;
      default:   next_state = S_HUNT;
    endcase
    if (tmo_hit) next_state = S_HUNT;
  end

  always_comb begin
    n_data  = data_o;
    n_valid = valid_o;
    n_last  = last_o;
    n_ok    = 1'b0;
    n_cerr  = 1'b0;
    n_lerr  = 1'b0;
    n_ovr   = 1'b0;
    n_len   = len_q;
    n_chk   = chk_acc;
    n_idx   = idx;
    n_rd    = rd_idx;
    wr_en   = 1'b0;
    case (state)
      S_LEN: if (byte_valid_i) begin
        if (len_ok) begin
          n_len = byte_i;
          n_chk = byte_i;
          n_idx = '0;
        end else begin
          n_lerr = 1'b1;
        end
      end
      S_PAYLOAD: if (byte_valid_i) begin
        wr_en = 1'b1;
        n_chk = chk_acc ^ byte_i;
        n_idx = idx + IW'(1);
      end
      S_CHECK: if (byte_valid_i) begin
        if (byte_i == chk_acc) begin
          n_ok    = 1'b1;
          n_valid = 1'b1;
          n_data  = pbuf[0];
          n_last  = (len_q == 8'd1);
          n_rd    = '0;
        end else begin
          n_cerr = 1'b1;
        end
      end
      S_DRAIN: begin
        n_ovr = byte_valid_i;
        if (handshake) begin
          if (last_o) begin
            n_valid = 1'b0;
            n_last  = 1'b0;
          end else begin
            n_rd   = rd_next;
            n_data = pbuf[rd_next[AW-1:0]];
            n_last = rd_last;
          end
        end
      end
      default: ;
    endcase
    n_busy = (next_state != S_HUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o     <= '0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      frame_ok_o <= 1'b0;
      chk_err_o  <= 1'b0;
      len_err_o  <= 1'b0;
      overrun_o  <= 1'b0;
      timeout_o  <= 1'b0;
      busy_o     <= 1'b0;
      len_q      <= '0;
      chk_acc    <= '0;
      idx        <= '0;
      rd_idx     <= '0;
    end else begin
      data_o     <= n_data;
      valid_o    <= n_valid;
      last_o     <= n_last;
      frame_ok_o <= n_ok;
      chk_err_o  <= n_cerr;
      len_err_o  <= n_lerr;
      overrun_o  <= n_ovr;
      timeout_o  <= tmo_hit;
      busy_o     <= n_busy;
      len_q      <= n_len;
      chk_acc    <= n_chk;
      idx        <= n_idx;
      rd_idx     <= n_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pbuf[idx[AW-1:0]] <= byte_i;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - table-driven self-checking bench for uart_frame_parser
// Timeout checks follow UART_FRAME_TIMEOUT_EN as defined for the build.
module tb_uart_frame_parser;

  localparam int TIMEOUT_CLKS = 17360;

  logic       clk = 1'b0;
  logic       rst, byte_valid_i, ready_i;
  logic [7:0] byte_i;
  logic [7:0] data_o;
  logic       valid_o, last_o, frame_ok_o, chk_err_o, len_err_o, overrun_o, timeout_o, busy_o;

  always #5 clk = ~clk;

  uart_frame_parser #(.MAX_LEN(16), .SYNC_BYTE(8'hAA), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
    .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
    .frame_ok_o(frame_ok_o), .chk_err_o(chk_err_o), .len_err_o(len_err_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  typedef struct {
    string      name;
    logic       bv;
    logic [7:0] b;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       el, eok, ece, ele, eov, ebusy;
  } vec_t;

  vec_t  tbl[$];
  string tag;
  int    checks = 0;
  int    errors = 0;

  // Packed outputs; data/last are only meaningful while valid is expected.
  function automatic logic [15:0] outs(input logic mask);
    return {valid_o, mask ? data_o : 8'h00, mask ? last_o : 1'b0,
            frame_ok_o, chk_err_o, len_err_o, overrun_o, timeout_o, busy_o};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic bv, input logic [7:0] b, input logic rdy);
    @(negedge clk);
    byte_valid_i = bv;
    byte_i       = b;
    ready_i      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic v(input logic bv, input logic [7:0] b, input logic rdy,
                   input logic ev, input logic [7:0] ed, input logic el,
                   input logic eok, input logic ece, input logic ele, input logic eov,
                   input logic ebusy);
    vec_t t;
    t.name = tag; t.bv = bv; t.b = b; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.el = el;
    t.eok = eok; t.ece = ece; t.ele = ele; t.eov = eov; t.ebusy = ebusy;
    tbl.push_back(t);
  endtask

  // A byte that only keeps the parser busy with no output activity.
  task automatic vb(input logic [7:0] b);
    v(1, b, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic idle(input logic ebusy);
    v(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0, ebusy);
  endtask

  initial begin
    logic [7:0] p [16];
    logic [7:0] chk;
    logic       seen;
    int         n;

    rst = 1'b1; byte_valid_i = 1'b0; byte_i = 8'h00; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", outs(1'b1), 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    tag = "good";
    vb(8'hAA); vb(8'h03); vb(8'h11); vb(8'h22); vb(8'h33);
    v(1, 8'h03, 1, 1, 8'h11, 0, 1, 0, 0, 0, 1);
    v(0, 8'h00, 1, 1, 8'h22, 0, 0, 0, 0, 0, 1);
    v(0, 8'h00, 1, 1, 8'h33, 1, 0, 0, 0, 0, 1);
    idle(0);

    tag = "bad_chk";
    vb(8'hAA); vb(8'h03); vb(8'h11); vb(8'h22); vb(8'h33);
    v(1, 8'h04, 1, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    idle(0);

    tag = "len1";
    vb(8'hAA); vb(8'h01); vb(8'h5A);
    v(1, 8'h5B, 1, 1, 8'h5A, 1, 1, 0, 0, 0, 1);
    idle(0);

    tag = "len_err";
    v(1, 8'h55, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    vb(8'hAA);
    v(1, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1, 0, 0);
    vb(8'hAA);
    v(1, 8'h11, 1, 0, 8'h00, 0, 0, 0, 1, 0, 0);
    vb(8'hAA);
    v(1, 8'hAA, 1, 0, 8'h00, 0, 0, 0, 1, 0, 0);
    idle(0);

    tag = "max_len";
    chk = 8'h10;
    for (int i = 0; i < 16; i++) begin
      p[i] = (i == 5) ? 8'hAA : 8'(i + 1);
      chk  = chk ^ p[i];
    end
    vb(8'hAA); vb(8'h10);
    for (int i = 0; i < 16; i++) vb(p[i]);
    v(1, chk, 1, 1, p[0], 0, 1, 0, 0, 0, 1);
    for (int k = 1; k < 16; k++) v(0, 8'h00, 1, 1, p[k], (k == 15), 0, 0, 0, 0, 1);
    idle(0);

    tag = "backpressure";
    vb(8'hAA); vb(8'h03); vb(8'h11); vb(8'h22); vb(8'h33);
    v(1, 8'h03, 1, 1, 8'h11, 0, 1, 0, 0, 0, 1);
    v(0, 8'h00, 1, 1, 8'h22, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) v(0, 8'h00, 0, 1, 8'h22, 0, 0, 0, 0, 0, 1);
    v(0, 8'h00, 1, 1, 8'h33, 1, 0, 0, 0, 0, 1);
    idle(0);

    tag = "overrun";
    vb(8'hAA); vb(8'h02); vb(8'h12); vb(8'h34);
    v(1, 8'h24, 0, 1, 8'h12, 0, 1, 0, 0, 0, 1);
    v(1, 8'h77, 0, 1, 8'h12, 0, 0, 0, 0, 1, 1);
    v(0, 8'h00, 0, 1, 8'h12, 0, 0, 0, 0, 0, 1);
    v(1, 8'h77, 1, 1, 8'h34, 1, 0, 0, 0, 1, 1);
    v(1, 8'h55, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    idle(0);
    vb(8'hAA); vb(8'h01); vb(8'h5A);
    v(1, 8'h5B, 1, 1, 8'h5A, 1, 1, 0, 0, 0, 1);
    idle(0);

    foreach (tbl[i]) begin
      step(tbl[i].bv, tbl[i].b, tbl[i].rdy);
      check($sformatf("%s[%0d]", tbl[i].name, i), outs(tbl[i].ev),
            {tbl[i].ev, tbl[i].ev ? tbl[i].ed : 8'h00, tbl[i].ev ? tbl[i].el : 1'b0,
             tbl[i].eok, tbl[i].ece, tbl[i].ele, tbl[i].eov, 1'b0, tbl[i].ebusy});
    end

    // Reset while a frame is waiting in DRAIN.
    step(1, 8'hAA, 0); step(1, 8'h01, 0); step(1, 8'h5A, 0); step(1, 8'h5B, 0);
    check("drain_before_rst", {valid_o, data_o, last_o}, {1'b1, 8'h5A, 1'b1});
    @(negedge clk);
    byte_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("drain_rst", outs(1'b1), 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Silence mid-frame.
    step(1, 8'hAA, 1); step(1, 8'h02, 1); step(1, 8'h11, 1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < TIMEOUT_CLKS + 50) begin
      step(0, 8'h00, 1);
      n++;
      if (timeout_o) seen = 1'b1;
    end
`ifdef UART_FRAME_TIMEOUT_EN
    check("timeout_seen", 16'(seen), 16'h0001);
    check("timeout_delay", 16'((n >= TIMEOUT_CLKS) && (n <= TIMEOUT_CLKS + 2)), 16'h0001);
    check("timeout_busy", 16'(busy_o), 16'h0000);
    step(0, 8'h00, 1);
    check("timeout_after", {14'h0, timeout_o, busy_o}, 16'h0000);
`else
    check("no_timeout", 16'(seen), 16'h0000);
    check("still_busy", 16'(busy_o), 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
`endif
    step(1, 8'hAA, 1); step(1, 8'h01, 1); step(1, 8'h42, 1); step(1, 8'h43, 1);
    check("after_timeout_frame", outs(1'b1), {1'b1, 8'h42, 1'b1, 6'b100001});
    step(0, 8'h00, 1);
    check("after_timeout_idle", outs(1'b0), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
